chk_param_sendesc: RTL and testbench

CHK_PARAM_SENDESC -- requirements
Module: chk_param_sendesc

---
 rtl/pcs_tb_pkg.sv | 20 ++
 rtl/chk_param_sendesc_if.sv | 14 +
 rtl/chk_lat_stat.sv | 39 +++
 rtl/chk_param_sendesc.sv | 162 ++++++++++++++++
 tb/tb_chk_param_sendesc.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcs_tb_pkg.sv
// Shared definitions for the sequence/escape checker: FSM states, the
// default escape tag and the positions of the tag and stamp fields.
package pcs_tb_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_e;

    // Tag byte that marks an escape/idle word.
    localparam logic [7:0] ESC_DEFAULT = 8'hFB;

    // The tag occupies the top TAG_W bits of the word.
    localparam int TAG_W = 8;

    // The stamp field starts this many bits below the word MSB, directly under the tag.
    localparam int STAMP_TOP_OFS = TAG_W;

endpackage

// File: rtl/chk_param_sendesc_if.sv
// Receive-side word stream into the checker: word, valid qualifier,
// receive time base and statistics clear.
interface chk_param_sendesc_if #(
    parameter int DW  = 192,
    parameter int TSW = 32
) ();
    logic           clr;
    logic [TSW-1:0] rcvtime;
    logic [DW-1:0]  data;
    logic           pop;

    modport master (output clr, rcvtime, data, pop);
    modport slave  (input  clr, rcvtime, data, pop);
endinterface

// File: rtl/chk_lat_stat.sv
// Latency statistics: latency = rcvtime - stamp (modulo 2^TSW), with
// last/min/max registers. clr wins over upd.
module chk_lat_stat #(
    parameter int TSW = 32
) (
    input  logic           clkcore,
    input  logic           reset_n,
    input  logic [TSW-1:0] rcvtime,
    input  logic [TSW-1:0] stamp,
    input  logic           upd,
    input  logic           clr,
    output logic [TSW-1:0] lat_last,
    output logic [TSW-1:0] lat_min,
    output logic [TSW-1:0] lat_max
);

    logic [TSW-1:0] lat;

    assign lat = rcvtime - stamp;

    // Track last/min/max latency; min idles at all-ones so the first sample always wins.
    always_ff @(posedge clkcore or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (!reset_n) begin
            lat_last <= '0;
            lat_min  <= '1;
            lat_max  <= '0;
        end else if (clr) begin
            lat_last <= '0;
            lat_min  <= '1;
            lat_max  <= '0;
        end else if (upd) begin
            lat_last <= lat;
            if (lat < lat_min) lat_min <= lat;
            if (lat > lat_max) lat_max <= lat;
        end
    end

endmodule

// File: rtl/chk_param_sendesc.sv
// Sequence-number checker: hunts for a consistent sequence, locks after
// LOCK_CNT good words, counts errors/good words and latency while locked,
// and drops lock after ERR_LIMIT consecutive bad words.
module chk_param_sendesc
    import pcs_tb_pkg::*;
#(
    parameter int         DW        = 192,
    parameter int         TSW       = 32,
    parameter int         SQW       = 32,
    parameter logic [7:0] ESC       = ESC_DEFAULT,
    parameter int         LOCK_CNT  = 4,
    parameter int         ERR_LIMIT = 8
) (
    input  logic                 clkcore,
    input  logic                 reset_n,
    chk_param_sendesc_if.slave   rx,
    output logic                 locked,
    output logic                 correct,
    output logic                 err_pulse,
    output logic [15:0]          err_cnt,
    output logic [31:0]          good_cnt,
    output logic [TSW-1:0]       lat_last,
    output logic [TSW-1:0]       lat_min,
    output logic [TSW-1:0]       lat_max
);

    localparam int TAG_LSB   = DW - TAG_W;
    localparam int STAMP_MSB = DW - 1 - STAMP_TOP_OFS;
    localparam int STAMP_LSB = STAMP_MSB - TSW + 1;
    localparam int PAD_MSB   = STAMP_LSB - 1;
    localparam int PAD_LSB   = SQW;
    localparam int RW        = $clog2(LOCK_CNT + 1);
    localparam int BW        = $clog2(ERR_LIMIT + 1);
    localparam logic [RW-1:0] LOCK_TGT = RW'(LOCK_CNT);
    localparam logic [BW-1:0] ERR_TGT  = BW'(ERR_LIMIT);

    logic [7:0]     tag;
    logic [TSW-1:0] stamp;
    logic [SQW-1:0] seq;
    logic           pad_ok;
    logic           word_live;
    logic           word_good;

    chk_state_e     state, state_n;
    logic [SQW-1:0] exp_seq, exp_seq_n;
    logic [RW-1:0]  run, run_n;
    logic [BW-1:0]  bad_run, bad_run_n;
    logic           good_lock;
    logic           bad_lock;

    assign tag       = rx.data[DW-1:TAG_LSB];
    assign stamp     = rx.data[STAMP_MSB:STAMP_LSB];
    assign seq       = rx.data[SQW-1:0];
    assign pad_ok    = (rx.data[PAD_MSB:PAD_LSB] == '0);
    assign word_live = rx.pop && (tag != ESC);
    assign word_good = word_live && (seq == exp_seq) && pad_ok;

    // Next-state logic: hunt/verify/locked transitions plus expected-seq and run counters.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_n   = state;
        exp_seq_n = exp_seq;
        run_n     = run;
        bad_run_n = bad_run;
        good_lock = 1'b0;
        bad_lock  = 1'b0;
        if (word_live) begin
            unique case (state)
                ST_HUNT: begin
                    exp_seq_n = seq + 1'b1;
                    run_n     = RW'(1);
                    state_n   = ST_VERIFY;
                end
                ST_VERIFY: begin
                    if (word_good) begin
                        exp_seq_n = exp_seq + 1'b1;
                        run_n     = run + 1'b1;
                        if (run_n == LOCK_TGT) begin
                            state_n   = ST_LOCKED;
                            bad_run_n = '0;
                        end
                    end else begin
                        state_n = ST_HUNT;
                        run_n   = '0;
                    end
                end
                ST_LOCKED: begin
                    if (word_good) begin
                        good_lock = 1'b1;
                        exp_seq_n = exp_seq + 1'b1;
                        bad_run_n = '0;
                    end else begin
                        // Resync on the received seq so a single drop costs one error.
                        bad_lock  = 1'b1;
                        exp_seq_n = seq + 1'b1;
                        bad_run_n = bad_run + 1'b1;
                        if (bad_run_n == ERR_TGT) begin
                            state_n   = ST_HUNT;
                            bad_run_n = '0;
                            run_n     = '0;
                        end
                    end
                end
                default: state_n = ST_HUNT;
            endcase
        end
    end

    // FSM state and sequence-tracking registers; clr leaves these alone.
    always_ff @(posedge clkcore or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_HUNT;
            exp_seq <= '0;
            run     <= '0;
            bad_run <= '0;
        end else begin
            state   <= state_n;
            exp_seq <= exp_seq_n;
            run     <= run_n;
            bad_run <= bad_run_n;
        end
    end

    // Registered status and counters; a word coinciding with clr is not counted.
    always_ff @(posedge clkcore or negedge reset_n) begin
        if (!reset_n) begin
            locked    <= 1'b0;
            correct   <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            good_cnt  <= '0;
        end else begin
            locked    <= (state_n == ST_LOCKED);
            err_pulse <= bad_lock;
            if ((state_n != ST_LOCKED) || bad_lock) begin
                correct <= 1'b0;
            end else if ((state != ST_LOCKED) || rx.clr) begin
                correct <= 1'b1;
            end
            if (rx.clr) begin
                err_cnt  <= '0;
                good_cnt <= '0;
            end else begin
                if (bad_lock && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 1'b1;
                if (good_lock) good_cnt <= good_cnt + 1'b1;
            end
        end
    end

    chk_lat_stat #(.TSW(TSW)) u_lat (
        .clkcore  (clkcore),
        .reset_n  (reset_n),
        .rcvtime  (rx.rcvtime),
        .stamp    (stamp),
        .upd      (good_lock && !rx.clr),
        .clr      (rx.clr),
        .lat_last (lat_last),
        .lat_min  (lat_min),
        .lat_max  (lat_max)
    );

endmodule

// File: tb/tb_chk_param_sendesc.sv
// Scoreboard bench for chk_param_sendesc: stimulus pushes the expected
// post-edge outputs from a behavioural model; a monitor pops and compares.
module tb_chk_param_sendesc;

    localparam int         DW        = 192;
    localparam int         TSW       = 32;
    localparam int         SQW       = 32;
    localparam logic [7:0] ESC       = 8'hFB;
    localparam int         LOCK_CNT  = 4;
    localparam int         ERR_LIMIT = 8;

    localparam int M_HUNT   = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    typedef struct {
        logic        locked;
        logic        correct;
        logic        err_pulse;
        logic [15:0] err_cnt;
        logic [31:0] good_cnt;
        logic [31:0] lat_last;
        logic [31:0] lat_min;
        logic [31:0] lat_max;
    } exp_t;

    logic           clkcore;
    logic           reset_n;
    logic           locked, correct, err_pulse;
    logic [15:0]    err_cnt;
    logic [31:0]    good_cnt;
    logic [TSW-1:0] lat_last, lat_min, lat_max;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t sb_q[$];

    // Behavioural model state
    int          m_mode;
    logic [31:0] m_exp;
    int          m_run;
    int          m_bad;
    bit          m_correct;
    bit          m_pulse;
    int unsigned m_err;
    int unsigned m_good;
    logic [31:0] hist[$];
    logic [31:0] next_seq;

    chk_param_sendesc_if #(.DW(DW), .TSW(TSW)) bus ();

    chk_param_sendesc #(
        .DW(DW), .TSW(TSW), .SQW(SQW), .ESC(ESC),
        .LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT)
    ) dut (
        .clkcore   (clkcore),
        .reset_n   (reset_n),
        .rx        (bus),
        .locked    (locked),
        .correct   (correct),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .good_cnt  (good_cnt),
        .lat_last  (lat_last),
        .lat_min   (lat_min),
        .lat_max   (lat_max)
    );

    initial clkcore = 1'b0;
    always #5 clkcore = ~clkcore;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [7:0] rand_tag();
        logic [7:0] t;
        t = 8'($urandom);
        if (t == ESC) t = 8'h00;
        return t;
    endfunction

    task automatic model_reset();
        m_mode    = M_HUNT;
        m_exp     = '0;
        m_run     = 0;
        m_bad     = 0;
        m_correct = 1'b0;
        m_pulse   = 1'b0;
        m_err     = 0;
        m_good    = 0;
        hist.delete();
    endtask

    task automatic push_expected();
        exp_t e;
        e.locked    = (m_mode == M_LOCKED);
        e.correct   = m_correct;
        e.err_pulse = m_pulse;
        e.err_cnt   = (m_err > 65535) ? 16'hFFFF : m_err[15:0];
        e.good_cnt  = m_good;
        e.lat_last  = 32'h0;
        e.lat_min   = 32'hFFFF_FFFF;
        e.lat_max   = 32'h0;
        if (hist.size() > 0) begin
            e.lat_last = hist[hist.size() - 1];
            foreach (hist[i]) begin
                if (hist[i] < e.lat_min) e.lat_min = hist[i];
                if (hist[i] > e.lat_max) e.lat_max = hist[i];
            end
        end
        sb_q.push_back(e);
    endtask

    // Applies one cycle of stimulus to the model, expressed as the rules
    // for hunting, verifying and staying locked.
    task automatic model_step(input bit p, input bit c, input logic [7:0] tag,
                              input logic [31:0] seq, input bit pad, input logic [31:0] lat);
        bit good;
        m_pulse = 1'b0;
        if (p && tag != ESC) begin
            good = (seq == m_exp) && !pad;
            if (m_mode == M_HUNT) begin
                m_exp  = seq + 1;
                m_run  = 1;
                m_mode = M_VERIFY;
            end else if (m_mode == M_VERIFY) begin
                if (good) begin
                    m_exp = m_exp + 1;
                    m_run = m_run + 1;
                    if (m_run == LOCK_CNT) begin
                        m_mode    = M_LOCKED;
                        m_bad     = 0;
                        m_correct = 1'b1;
                    end
                end else begin
                    m_mode = M_HUNT;
                end
            end else begin
                if (good) begin
                    m_exp = m_exp + 1;
                    m_bad = 0;
                    if (!c) begin
                        m_good = m_good + 1;
                        hist.push_back(lat);
                    end
                end else begin
                    m_exp     = seq + 1;
                    m_pulse   = 1'b1;
                    m_correct = 1'b0;
                    if (!c) m_err = m_err + 1;
                    m_bad = m_bad + 1;
                    if (m_bad == ERR_LIMIT) m_mode = M_HUNT;
                end
            end
        end
        if (c) begin
            m_err  = 0;
            m_good = 0;
            hist.delete();
            if (m_mode == M_LOCKED && !m_pulse) m_correct = 1'b1;
        end
        if (m_mode != M_LOCKED) m_correct = 1'b0;
        push_expected();
    endtask

    // Drives one cycle; stamp is chosen so that rcvtime - stamp == lat.
    task automatic drive(input bit p, input bit c, input logic [7:0] tag,
                         input logic [31:0] seq, input bit pad, input logic [31:0] lat);
        logic [31:0]   t;
        logic [DW-1:0] d;
        t = $urandom;
        d = '0;
        d[DW-1 -: 8]   = tag;
        d[DW-9 -: TSW] = t - lat;
        d[SQW-1:0]     = seq;
        if (pad) d[SQW + int'($urandom_range(0, DW - 9 - TSW - SQW))] = 1'b1;
        bus.pop     = p;
        bus.clr     = c;
        bus.rcvtime = t;
        bus.data    = d;
        model_step(p, c, tag, seq, pad, lat);
        @(posedge clkcore);
        #2;
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            bus.pop = 1'b0;
            bus.clr = 1'b0;
            model_reset();
            push_expected();
            @(posedge clkcore);
            #2;
        end
    endtask

    task automatic random_phase(input int n);
        int          r;
        logic [31:0] lat;
        logic [31:0] s;
        for (int i = 0; i < n; i++) begin
            r   = $urandom_range(0, 99);
            lat = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 1000);
            if (r < 8) begin
                drive(1'b0, 1'b0, rand_tag(), $urandom, 1'b0, lat);
            end else if (r < 14) begin
                drive(1'b1, 1'b0, ESC, $urandom, 1'b0, lat);
            end else if (r < 20) begin
                s = next_seq + $urandom_range(1, 5);
                drive(1'b1, 1'b0, rand_tag(), s, 1'b0, lat);
                next_seq = s + 1;
            end else if (r < 24) begin
                drive(1'b1, 1'b0, rand_tag(), next_seq, 1'b1, lat);
                next_seq = next_seq + 1;
            end else if (r < 26) begin
                drive(1'b0, 1'b1, rand_tag(), $urandom, 1'b0, lat);
            end else if (r < 28) begin
                drive(1'b1, 1'b1, rand_tag(), next_seq, 1'b0, lat);
                next_seq = next_seq + 1;
            end else if (r < 30) begin
                s = $urandom;
                drive(1'b1, 1'b0, rand_tag(), s, 1'b0, lat);
                next_seq = s + 1;
            end else begin
                drive(1'b1, 1'b0, rand_tag(), next_seq, 1'b0, lat);
                next_seq = next_seq + 1;
            end
        end
    endtask

    // Monitor: one expected record per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clkcore);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("locked",    locked,    e.locked);
                check("correct",   correct,   e.correct);
                check("err_pulse", err_pulse, e.err_pulse);
                check("err_cnt",   err_cnt,   e.err_cnt);
                check("good_cnt",  good_cnt,  e.good_cnt);
                check("lat_last",  lat_last,  e.lat_last);
                check("lat_min",   lat_min,   e.lat_min);
                check("lat_max",   lat_max,   e.lat_max);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, queue depth %0d", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        bus.pop     = 1'b0;
        bus.clr     = 1'b0;
        bus.rcvtime = '0;
        bus.data    = '0;
        model_reset();
        @(posedge clkcore);
        #2;
        hold_reset(3);
        reset_n = 1'b1;

        // Lock-up on seq 0..9 with latency 5, ESC/idle words between 5 and 6
        for (int s = 0; s < 10; s++) begin
            drive(1'b1, 1'b0, rand_tag(), s, 1'b0, 32'd5);
            if (s == 2) check("lock_not_yet", locked, 1'b0);
            if (s == 3) check("lock_after_w3", locked, 1'b1);
            if (s == 5) begin
                drive(1'b1, 1'b0, ESC, 32'h77, 1'b0, 32'd9);
                drive(1'b0, 1'b0, rand_tag(), 32'd9, 1'b0, 32'd9);
                drive(1'b1, 1'b0, ESC, 32'd6, 1'b1, 32'd9);
            end
        end
        check("lock_good_cnt", good_cnt, 32'd6);
        check("lock_lat_min",  lat_min,  32'd5);
        check("lock_lat_max",  lat_max,  32'd5);
        check("lock_correct",  correct,  1'b1);
        check("lock_err_cnt",  err_cnt,  16'd0);

        // Single drop: 19 then 21
        for (int s = 10; s < 20; s++) drive(1'b1, 1'b0, rand_tag(), s, 1'b0, 32'd7);
        drive(1'b1, 1'b0, rand_tag(), 32'd21, 1'b0, 32'd7);
        check("drop_pulse", err_pulse, 1'b1);
        for (int s = 22; s < 26; s++) begin
            drive(1'b1, 1'b0, rand_tag(), s, 1'b0, 32'd7);
            check("drop_no_more_pulse", err_pulse, 1'b0);
        end
        check("drop_err_cnt",  err_cnt,  16'd1);
        check("drop_correct",  correct,  1'b0);
        check("drop_good_cnt", good_cnt, 32'd20);

        // Sequence wrap while locked (FFFFFFFD resyncs first, costing one error)
        drive(1'b1, 1'b0, rand_tag(), 32'hFFFF_FFFD, 1'b0, 32'd3);
        drive(1'b1, 1'b0, rand_tag(), 32'hFFFF_FFFE, 1'b0, 32'd3);
        drive(1'b1, 1'b0, rand_tag(), 32'hFFFF_FFFF, 1'b0, 32'd3);
        drive(1'b1, 1'b0, rand_tag(), 32'h0000_0000, 1'b0, 32'd3);
        drive(1'b1, 1'b0, rand_tag(), 32'h0000_0001, 1'b0, 32'd3);
        check("wrap_err_cnt",  err_cnt,  16'd2);
        check("wrap_good_cnt", good_cnt, 32'd24);
        check("wrap_locked",   locked,   1'b1);

        // clr while locked re-arms correct, then 8 bad words drop lock
        drive(1'b0, 1'b1, rand_tag(), 32'd0, 1'b0, 32'd0);
        check("clr_rearm_correct", correct, 1'b1);
        check("clr_err_cnt",       err_cnt, 16'd0);
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b0, rand_tag(), 32'(k * 1000), 1'b0, 32'd4);
            if (k == 7) check("bad7_still_locked", locked, 1'b1);
        end
        check("bad8_err_cnt", err_cnt, 16'd8);
        check("bad8_unlock",  locked,  1'b0);
        for (int s = 500; s < 504; s++) drive(1'b1, 1'b0, rand_tag(), s, 1'b0, 32'd5);
        check("relock_locked",  locked,   1'b1);
        check("relock_correct", correct,  1'b1);
        check("relock_good",    good_cnt, 32'd0);

        // clr coincident with a good pop
        drive(1'b1, 1'b0, rand_tag(), 32'd504, 1'b0, 32'd11);
        check("pre_clr_good", good_cnt, 32'd1);
        drive(1'b1, 1'b1, rand_tag(), 32'd505, 1'b0, 32'd12);
        check("clrpop_good",    good_cnt, 32'd0);
        check("clrpop_lat_min", lat_min,  32'hFFFF_FFFF);
        check("clrpop_lat_max", lat_max,  32'd0);
        next_seq = 32'd506;

        random_phase(300);

        // Asynchronous reset mid-run
        reset_n = 1'b0;
        #1;
        check("arst_locked",   locked,   1'b0);
        check("arst_correct",  correct,  1'b0);
        check("arst_err_cnt",  err_cnt,  16'd0);
        check("arst_good_cnt", good_cnt, 32'd0);
        check("arst_lat_min",  lat_min,  32'hFFFF_FFFF);
        check("arst_lat_max",  lat_max,  32'd0);
        check("arst_lat_last", lat_last, 32'd0);
        hold_reset(2);
        reset_n = 1'b1;
        for (int s = 9000; s < 9004; s++) drive(1'b1, 1'b0, rand_tag(), s, 1'b0, 32'd6);
        check("rehunt_locked", locked, 1'b1);
        next_seq = 32'd9004;

        random_phase(150);

        bus.pop = 1'b0;
        bus.clr = 1'b0;
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clkcore);
        #2;
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
